// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
//   Write-side front end for the 32x32 register file. Writeback requests are
//   buffered in an in-order FIFO and drained at most one per cycle onto the
//   registered regfile write port (RegWrite/WriteReg/WriteData). Pending-write
//   hazards are reported for both regfile read addresses.
//
//   Optional feature macro: WBQ_FWD_EN
//     When defined, fwd_data1/fwd_data2 carry the data of the youngest pending
//     write to ReadReg1/ReadReg2 (newest FIFO entry first, output stage last).
//     When undefined, those ports and the forwarding mux do not exist.
//
//   Handshake: a request transfers on a rising clock edge where
//   in_valid && in_ready. in_ready depends only on the current occupancy
//   (count < DEPTH), never on in_valid or on a pop in the same cycle, so there
//   is no combinational path from in_valid to in_ready and no pass-through
//   when full. A transferred request for register 0 completes the handshake
//   but is dropped.

module reg_writeback_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ADDR_W-1:0]       in_reg,
   input  logic [DATA_W-1:0]       in_data,
   input  logic                    wb_stall,
   output logic                    RegWrite,
   output logic [ADDR_W-1:0]       WriteReg,
   output logic [DATA_W-1:0]       WriteData,
   input  logic [ADDR_W-1:0]       ReadReg1,
   input  logic [ADDR_W-1:0]       ReadReg2,
   output logic                    hazard1,
   output logic                    hazard2,
   output logic [$clog2(DEPTH):0]  count
`ifdef WBQ_FWD_EN
   ,
   output logic [DATA_W-1:0]       fwd_data1,
   output logic [DATA_W-1:0]       fwd_data2
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // FIFO storage and pointers
   logic [ADDR_W-1:0] mem_reg  [DEPTH];
   logic [DATA_W-1:0] mem_data [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;

   // Per-slot age relative to the head (0 = oldest) and occupancy
   logic [PW-1:0]     age [DEPTH];
   logic [DEPTH-1:0]  occ;

   logic              accept;
   logic              push;
   logic              pop;

   // Per-slot address matches against both read ports
   logic [DEPTH-1:0]  hit1;
   logic [DEPTH-1:0]  hit2;
   logic              out_hit1;
   logic              out_hit2;

   // Handshake, enqueue and dequeue qualifiers
   always_comb begin
      in_ready = (count < CW'(DEPTH));
      accept   = in_valid && in_ready;
      push     = accept && (in_reg != '0);
      pop      = (count != '0) && !wb_stall;
   end

   // Slot age and occupancy: a slot is live when its distance from the head
   // is below the occupancy count; pointer arithmetic wraps modulo DEPTH
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         age[i] = PW'(i) - rd_ptr;
         occ[i] = ({1'b0, age[i]} < count);
      end
   end

   // Write incoming requests into the tail slot
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i]  <= '0;
            mem_data[i] <= '0;
         end
      end else if (push) begin
         mem_reg[wr_ptr]  <= in_reg;
         mem_data[wr_ptr] <= in_data;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Registered regfile write port: load the head on a pop, otherwise hold
   // address/data and drop the enable
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         RegWrite  <= 1'b0;
         WriteReg  <= '0;
         WriteData <= '0;
      end else if (pop) begin
         RegWrite  <= 1'b1;
         WriteReg  <= mem_reg[rd_ptr];
         WriteData <= mem_data[rd_ptr];
      end else begin
         RegWrite  <= 1'b0;
      end
   end

   // Address matches against live FIFO slots and the active output stage
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         hit1[i] = occ[i] && (mem_reg[i] == ReadReg1);
         hit2[i] = occ[i] && (mem_reg[i] == ReadReg2);
      end
      out_hit1 = RegWrite && (WriteReg == ReadReg1);
      out_hit2 = RegWrite && (WriteReg == ReadReg2);
   end

   // Hazard flags; register 0 is never a hazard and a request being accepted
   // this cycle is not yet visible
   always_comb begin
      hazard1 = (ReadReg1 != '0) && ((|hit1) || out_hit1);
      hazard2 = (ReadReg2 != '0) && ((|hit2) || out_hit2);
   end

`ifdef WBQ_FWD_EN
   logic          found1;
   logic          found2;
   logic [PW-1:0] best_age1;
   logic [PW-1:0] best_age2;

   // Forwarding mux: output stage is the fallback, any matching FIFO slot
   // overrides it and among slots the largest age (youngest) wins
   always_comb begin
      fwd_data1 = '0;
      fwd_data2 = '0;
      found1    = 1'b0;
      found2    = 1'b0;
      best_age1 = '0;
      best_age2 = '0;
      if (out_hit1) begin
         fwd_data1 = WriteData;
      end
      if (out_hit2) begin
         fwd_data2 = WriteData;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (hit1[i] && (!found1 || (age[i] > best_age1))) begin
            found1    = 1'b1;
            best_age1 = age[i];
            fwd_data1 = mem_data[i];
         end
         if (hit2[i] && (!found2 || (age[i] > best_age2))) begin
            found2    = 1'b1;
            best_age2 = age[i];
            fwd_data2 = mem_data[i];
         end
      end
      if (!hazard1) begin
         fwd_data1 = '0;
      end
      if (!hazard2) begin
         fwd_data2 = '0;
      end
   end
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue
//   Directed bench for reg_writeback_queue. Pushed requests enter an expected
//   queue; a negedge monitor compares every regfile write against it in order.
//   Define WBQ_FWD_EN for both files to also check the forwarding outputs.

module tb_reg_writeback_queue;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic                    clock = 1'b0;
   logic                    reset_n;
   logic                    in_valid;
   logic                    in_ready;
   logic [ADDR_W-1:0]       in_reg;
   logic [DATA_W-1:0]       in_data;
   logic                    wb_stall;
   logic                    RegWrite;
   logic [ADDR_W-1:0]       WriteReg;
   logic [DATA_W-1:0]       WriteData;
   logic [ADDR_W-1:0]       ReadReg1;
   logic [ADDR_W-1:0]       ReadReg2;
   logic                    hazard1;
   logic                    hazard2;
   logic [$clog2(DEPTH):0]  count;
`ifdef WBQ_FWD_EN
   logic [DATA_W-1:0]       fwd_data1;
   logic [DATA_W-1:0]       fwd_data2;
`endif

   int checks = 0;
   int errors = 0;

   logic [ADDR_W+DATA_W-1:0] exp_q [$];
   logic [ADDR_W+DATA_W-1:0] mon_e;

   reg_writeback_queue #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_reg    (in_reg),
      .in_data   (in_data),
      .wb_stall  (wb_stall),
      .RegWrite  (RegWrite),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .ReadReg1  (ReadReg1),
      .ReadReg2  (ReadReg2),
      .hazard1   (hazard1),
      .hazard2   (hazard2),
      .count     (count)
`ifdef WBQ_FWD_EN
      ,
      .fwd_data1 (fwd_data1),
      .fwd_data2 (fwd_data2)
`endif
   );

   // Clock
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   // One accepted push; register 0 is dropped by the DUT so it is not expected
   task automatic push(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
      in_valid = 1'b1;
      in_reg   = r;
      in_data  = d;
      if (r != '0) exp_q.push_back({r, d});
      tick();
      in_valid = 1'b0;
   endtask

   // Scoreboard: every regfile write must match the oldest expected push
   always @(negedge clock) begin
      if (reset_n === 1'b1 && RegWrite === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("wb_unexpected", 64'(RegWrite), 64'(0));
         end else begin
            mon_e = exp_q.pop_front();
            check("wb_reg", 64'(WriteReg), 64'(mon_e[ADDR_W+DATA_W-1:DATA_W]));
            check("wb_data", 64'(WriteData), 64'(mon_e[DATA_W-1:0]));
         end
      end
   end

   initial begin
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_reg   = '0;
      in_data  = '0;
      wb_stall = 1'b0;
      ReadReg1 = '0;
      ReadReg2 = '0;

      // Reset values
      #3;
      check("rst_count", 64'(count), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_regwrite", 64'(RegWrite), 64'(0));
      check("rst_writereg", 64'(WriteReg), 64'(0));
      check("rst_writedata", 64'(WriteData), 64'(0));
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // 1. Single write
      push(5'd5, 32'hDEADBEEF);
      check("t1_count_after_push", 64'(count), 64'(1));
      check("t1_regwrite_early", 64'(RegWrite), 64'(0));
      tick();
      check("t1_regwrite", 64'(RegWrite), 64'(1));
      check("t1_writereg", 64'(WriteReg), 64'(5));
      check("t1_writedata", 64'(WriteData), 64'(32'hDEADBEEF));
      check("t1_count_drained", 64'(count), 64'(0));
      tick();
      check("t1_regwrite_off", 64'(RegWrite), 64'(0));
      check("t1_writereg_hold", 64'(WriteReg), 64'(5));

      // 2. Fill under stall, refused 5th push, then ordered drain
      wb_stall = 1'b1;
      for (int i = 1; i <= 4; i++) push(ADDR_W'(i), 32'h100 + 32'(i));
      check("t2_count_full", 64'(count), 64'(4));
      check("t2_in_ready_full", 64'(in_ready), 64'(0));
      in_valid = 1'b1;
      in_reg   = 5'd9;
      in_data  = 32'h999;
      #1;
      check("t2_in_ready_5th", 64'(in_ready), 64'(0));
      tick();
      in_valid = 1'b0;
      check("t2_count_5th", 64'(count), 64'(4));
      wb_stall = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("t2_regwrite", 64'(RegWrite), 64'(1));
         check("t2_writereg", 64'(WriteReg), 64'(i));
         check("t2_count", 64'(count), 64'(4 - i));
      end
      tick();
      check("t2_regwrite_off", 64'(RegWrite), 64'(0));

      // 3. Register 0 handshakes but never reaches the regfile
      in_valid = 1'b1;
      in_reg   = 5'd0;
      in_data  = 32'h1234;
      ReadReg1 = 5'd0;
      #1;
      check("t3_in_ready", 64'(in_ready), 64'(1));
      check("t3_hazard1_r0", 64'(hazard1), 64'(0));
      tick();
      in_valid = 1'b0;
      check("t3_count", 64'(count), 64'(0));
      check("t3_regwrite_a", 64'(RegWrite), 64'(0));
      tick();
      check("t3_regwrite_b", 64'(RegWrite), 64'(0));

      // 4. Hazard and forwarding
      wb_stall = 1'b1;
      ReadReg1 = 5'd7;
      ReadReg2 = 5'd8;
      in_valid = 1'b1;
      in_reg   = 5'd7;
      in_data  = 32'h11;
      exp_q.push_back({5'd7, 32'h11});
      #1;
      check("t4_hazard_accepting", 64'(hazard1), 64'(0));
      tick();
      push(5'd7, 32'h22);
      check("t4_hazard1", 64'(hazard1), 64'(1));
      check("t4_hazard2", 64'(hazard2), 64'(0));
`ifdef WBQ_FWD_EN
      check("t4_fwd1", 64'(fwd_data1), 64'(32'h22));
      check("t4_fwd2", 64'(fwd_data2), 64'(0));
`endif
      wb_stall = 1'b0;
      tick();
      check("t4_hazard1_mixed", 64'(hazard1), 64'(1));
      check("t4_count_mixed", 64'(count), 64'(1));
`ifdef WBQ_FWD_EN
      check("t4_fwd1_mixed", 64'(fwd_data1), 64'(32'h22));
`endif
      tick();
      check("t4_hazard1_outstage", 64'(hazard1), 64'(1));
      check("t4_count_outstage", 64'(count), 64'(0));
`ifdef WBQ_FWD_EN
      check("t4_fwd1_outstage", 64'(fwd_data1), 64'(32'h22));
`endif
      tick();
      check("t4_hazard1_clear", 64'(hazard1), 64'(0));
`ifdef WBQ_FWD_EN
      check("t4_fwd1_clear", 64'(fwd_data1), 64'(0));
`endif
      ReadReg1 = '0;
      ReadReg2 = '0;

      // 5. Concurrent push/pop with two resident entries and pointer wrap
      wb_stall = 1'b1;
      push(5'd10, 32'hA0);
      push(5'd11, 32'hA1);
      wb_stall = 1'b0;
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1;
         in_reg   = ADDR_W'(12 + k);
         in_data  = 32'hB0 + 32'(k);
         exp_q.push_back({in_reg, in_data});
         tick();
         check("t5_count_steady", 64'(count), 64'(2));
      end
      in_valid = 1'b0;
      tick();
      check("t5_count_drain1", 64'(count), 64'(1));
      tick();
      check("t5_count_drain0", 64'(count), 64'(0));
      tick();
      check("t5_regwrite_off", 64'(RegWrite), 64'(0));

      // 6. Reset mid-operation discards pending writes
      wb_stall = 1'b1;
      push(5'd3, 32'h33);
      push(5'd4, 32'h44);
      push(5'd6, 32'h66);
      check("t6_count_queued", 64'(count), 64'(3));
      wb_stall = 1'b0;
      tick();
      check("t6_regwrite_before", 64'(RegWrite), 64'(1));
      #1;
      reset_n = 1'b0;
      exp_q.delete();
      #1;
      check("t6_count_reset", 64'(count), 64'(0));
      check("t6_regwrite_reset", 64'(RegWrite), 64'(0));
      check("t6_writereg_reset", 64'(WriteReg), 64'(0));
      check("t6_in_ready_reset", 64'(in_ready), 64'(1));
      tick();
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t6_regwrite_after", 64'(RegWrite), 64'(0));
         check("t6_count_after", 64'(count), 64'(0));
      end

      check("exp_q_empty", 64'(exp_q.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
